accel_dispatch_ctrl: RTL

Sequencer for the GPU's matrix-add accelerator path. It accepts one MATADD command from the issue stage: base addresses A, B and C, plus an element count. It then walks the scratchpad in LANES-wide chunks, reading A, reading B, and writing C = A + B with a tail mask. The scratchpad port is shared through the scratchpad arbiter, so every access uses a req/gnt handshake. The core stalls on `busy` and retires the instruction on `done`.

---
 rtl/accel_dispatch_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/accel_dispatch_ctrl.sv
// Matrix-add sequencer: walks A/B/C in LANES-wide chunks, C = A + B (or A - B), tail-masked writes.
// Latency: 5 cycles per chunk with grant held high, plus one DONE cycle; len==0 completes in 1 cycle.
// Backpressure: each withheld mem_gnt_i stalls one cycle with mem_* held stable; cmd_ready_o only in IDLE.
// Optional feature: define ACCEL_MATSUB_EN to honour cmd_sub_i (A - B); otherwise always A + B.
module accel_dispatch_ctrl #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_sub_i,
   input  logic [ADDR_W-1:0]         cmd_base_a_i,
   input  logic [ADDR_W-1:0]         cmd_base_b_i,
   input  logic [ADDR_W-1:0]         cmd_base_c_i,
   input  logic [7:0]                cmd_len_i,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic                      mem_we_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [LANES*DATA_W-1:0]   mem_wdata_o,
   output logic [LANES-1:0]          mem_wmask_o,
   input  logic [LANES*DATA_W-1:0]   mem_rdata_i,
   output logic                      busy_o,
   output logic                      done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_WR, S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [8:0]                off_q, off_d;
   logic [7:0]                len_q, len_d;
   logic [ADDR_W-1:0]         base_a_q, base_a_d;
   logic [ADDR_W-1:0]         base_b_q, base_b_d;
   logic [ADDR_W-1:0]         base_c_q, base_c_d;
   logic [LANES*DATA_W-1:0]   a_q, a_d;
   logic [LANES*DATA_W-1:0]   b_q, b_d;
   logic [LANES*DATA_W-1:0]   res_w;
   logic [LANES-1:0]          mask_w;
   logic [ADDR_W-1:0]         off_a;
   logic                      last_chunk;

`ifdef ACCEL_MATSUB_EN
   logic                      sub_q, sub_d;
`else
   logic                      unused_sub;
   assign unused_sub = cmd_sub_i;
`endif

   // offset truncated to address width so chunk addresses wrap modulo 2^ADDR_W
   assign off_a      = ADDR_W'(off_q);
   // decided on the pre-increment offset: this chunk covers everything up to len
   assign last_chunk = ({1'b0, off_q} + 10'(LANES)) >= {2'b00, len_q};

   // per-lane result and tail mask for the current chunk
   always_comb begin
      res_w  = '0;
      mask_w = '0;
      for (int i = 0; i < LANES; i++) begin
`ifdef ACCEL_MATSUB_EN
         if (sub_q) begin
            res_w[i*DATA_W +: DATA_W] = a_q[i*DATA_W +: DATA_W] - b_q[i*DATA_W +: DATA_W];
         end else begin
            res_w[i*DATA_W +: DATA_W] = a_q[i*DATA_W +: DATA_W] + b_q[i*DATA_W +: DATA_W];
         end
`else
         res_w[i*DATA_W +: DATA_W] = a_q[i*DATA_W +: DATA_W] + b_q[i*DATA_W +: DATA_W];
`endif
         mask_w[i] = ({1'b0, off_q} + 10'(i)) < {2'b00, len_q};
      end
   end

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         off_q    <= '0;
         len_q    <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
         base_c_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
`ifdef ACCEL_MATSUB_EN
         sub_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         len_q    <= len_d;
         base_a_q <= base_a_d;
         base_b_q <= base_b_d;
         base_c_q <= base_c_d;
         a_q      <= a_d;
         b_q      <= b_d;
`ifdef ACCEL_MATSUB_EN
         sub_q    <= sub_d;
`endif
      end
   end

   // next-state, datapath next values and all outputs
   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      len_d       = len_q;
      base_a_d    = base_a_q;
      base_b_d    = base_b_q;
      base_c_d    = base_c_q;
      a_d         = a_q;
      b_d         = b_q;
`ifdef ACCEL_MATSUB_EN
      sub_d       = sub_q;
`endif
      cmd_ready_o = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wmask_o = '0;
      case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (cmd_valid_i) begin
               base_a_d = cmd_base_a_i;
               base_b_d = cmd_base_b_i;
               base_c_d = cmd_base_c_i;
               len_d    = cmd_len_i;
               off_d    = '0;
`ifdef ACCEL_MATSUB_EN
               sub_d    = cmd_sub_i;
`endif
               state_d  = (cmd_len_i == 8'd0) ? S_DONE : S_RD_A;
            end
         end
         S_RD_A: begin
            mem_req_o  = 1'b1;
            mem_addr_o = base_a_q + off_a;
            if (mem_gnt_i) state_d = S_WAIT_A;
         end
         S_WAIT_A: begin
            a_d     = mem_rdata_i;
            state_d = S_RD_B;
         end
         S_RD_B: begin
            mem_req_o  = 1'b1;
            mem_addr_o = base_b_q + off_a;
            if (mem_gnt_i) state_d = S_WAIT_B;
         end
         S_WAIT_B: begin
            b_d     = mem_rdata_i;
            state_d = S_WR;
         end
         S_WR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = base_c_q + off_a;
            mem_wdata_o = res_w;
            mem_wmask_o = mask_w;
            if (mem_gnt_i) begin
               off_d   = off_q + 9'(LANES);
               state_d = last_chunk ? S_DONE : S_RD_A;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // a grant landing on a reset edge must not complete an access
      if (!rst_n_i) begin
         mem_req_o = 1'b0;
         mem_we_o  = 1'b0;
      end
   end

endmodule
